// File: rtl/accum_sat_mc.sv
// accum_sat_mc
//   Multi-channel signed accumulator with optional saturation and sticky
//   per-channel overflow flags. Each accepted transaction either loads or
//   accumulates into one channel. The updated value comes out as a result
//   beat one cycle later through a single-entry valid/ready output register.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   valid_i      input transaction valid
//   ready_o      input accepted when valid_i && ready_o
//   ch_i         target channel
//   load_i       1 = load channel with data_i, 0 = accumulate
//   data_i       signed input sample
//   sat_i        1 = saturate on overflow, 0 = wrap
//   flush_i      synchronous clear of all channels and flags
//   out_valid_o  result beat valid
//   out_ready_i  downstream accepts result beat
//   out_ch_o     channel of result beat
//   result_o     updated accumulator value
//   ovf_o        transaction behind this beat overflowed
//   ovf_flags_o  per-channel sticky overflow flags
module accum_sat_mc #(
    parameter int DIN_WIDTH  = 32,
    parameter int DOUT_WIDTH = 40,
    parameter int NUM_CH     = 4,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [CH_W-1:0]              ch_i,
    input  logic                         load_i,
    input  logic signed [DIN_WIDTH-1:0]  data_i,
    input  logic                         sat_i,
    input  logic                         flush_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [CH_W-1:0]              out_ch_o,
    output logic signed [DOUT_WIDTH-1:0] result_o,
    output logic                         ovf_o,
    output logic [NUM_CH-1:0]            ovf_flags_o
);

    generate
        if (DOUT_WIDTH < DIN_WIDTH) begin : g_bad_width
            $error("accum_sat_mc: DOUT_WIDTH must be >= DIN_WIDTH");
        end
        if (NUM_CH < 2) begin : g_bad_ch
            $error("accum_sat_mc: NUM_CH must be >= 2");
        end
    endgenerate

    localparam logic signed [DOUT_WIDTH-1:0] SAT_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [DOUT_WIDTH-1:0] SAT_MIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    logic signed [DOUT_WIDTH-1:0] acc [NUM_CH];

    logic                         accept;
    logic signed [DOUT_WIDTH-1:0] acc_cur;
    logic signed [DOUT_WIDTH-1:0] acc_new;
    logic signed [DOUT_WIDTH:0]   sum;
    logic                         ovf_new;
    logic                         flag_prior;

    assign ready_o = !out_valid_o || out_ready_i;
    assign accept  = valid_i && ready_o;

    // A flush coinciding with a transaction makes the target channel read
    // as zero with a clear flag, so the transaction sees post-flush state.
    always_comb begin
        acc_cur    = flush_i ? '0 : acc[ch_i];
        flag_prior = flush_i ? 1'b0 : ovf_flags_o[ch_i];
        sum        = (DOUT_WIDTH+1)'(acc_cur) + (DOUT_WIDTH+1)'(data_i);
        ovf_new    = 1'b0;
        acc_new    = sum[DOUT_WIDTH-1:0];
        if (load_i) begin
            acc_new = DOUT_WIDTH'(data_i);
        end else if (sum[DOUT_WIDTH] != sum[DOUT_WIDTH-1]) begin
            ovf_new = 1'b1;
            if (sat_i) begin
                // Top bit of the widened sum gives the true sign of the result.
                acc_new = sum[DOUT_WIDTH] ? SAT_MIN : SAT_MAX;
            end
        end
    end

    // Channel update; the accepted write is placed after the flush clear so
    // it wins on its own channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
            end
            ovf_flags_o <= '0;
        end else begin
            if (flush_i) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    acc[i] <= '0;
                end
                ovf_flags_o <= '0;
            end
            if (accept) begin
                acc[ch_i]         <= acc_new;
                ovf_flags_o[ch_i] <= load_i ? 1'b0 : (flag_prior | ovf_new);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
            out_ch_o    <= '0;
            result_o    <= '0;
            ovf_o       <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_ch_o    <= ch_i;
            result_o    <= acc_new;
            ovf_o       <= ovf_new;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule
